// File: rtl/student_adder_pkg.sv
// Shared definitions for the serial adder slice.
//   state_t        : FSM encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : default operand width
package student_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/student_full_adder.sv
// 1-bit full adder slice.
//   a, b  : operand bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : majority(a, b, c)
module student_full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/student_serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
// through a single full-adder slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an addition (accepted in IDLE or DONE)
//   a, b, cin  : operands, captured on an accepted start
//   busy       : high while the addition is running
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : result, held until the next addition overwrites it
module student_serial_adder
    import student_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, nstate;
    logic [WIDTH-1:0] opa, opb, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] mask;
    logic             bit_a, bit_b, fa_s, fa_c;
    logic             last, accept;

    // One-hot select of the bit under processing; reduction avoids a
    // variable part-select and keeps every operand bit in use.
    assign mask   = WIDTH'(1) << cnt;
    assign bit_a  = |(opa & mask);
    assign bit_b  = |(opb & mask);
    assign last   = (cnt == CW'(WIDTH - 1));
    // A start while running is dropped here, so the operands stay frozen.
    assign accept = start && (state != RUN);

    student_full_adder u_fa (
        .a     (bit_a),
        .b     (bit_b),
        .c     (carry_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = start ? RUN : IDLE;
            RUN:     nstate = last ? DONE : RUN;
            DONE:    nstate = start ? RUN : IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Datapath: operand capture and per-bit accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            opa     <= a;
            opb     <= b;
            carry_q <= cin;
            cnt     <= '0;
        end else if (state == RUN) begin
            sum_q   <= (sum_q & ~mask) | (fa_s ? mask : '0);
            carry_q <= fa_c;
            cnt     <= cnt + CW'(1);
            if (last) cout_q <= fa_c;
        end
    end

    // Outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: doc/student_serial_adder.md
STUDENT_SERIAL_ADDER -- requirements
Module: student_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled at the rising edge.
REQ-005 a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 sum  output  WIDTH  result, valid from done and held until the next accepted start.
REQ-011 cout  output  1  carry-out of the MSB; same validity as sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin, one bit per clock, LSB first, through a single 1-bit full-adder slice.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE or DONE with start=1 at an edge SHALL move to RUN, capture a, b and cin into internal registers, and clear the bit counter to 0.
REQ-015 IDLE with start=0 SHALL remain in IDLE.
REQ-016 DONE with start=0 SHALL move to IDLE.
REQ-017 RUN: each edge SHALL feed operand bit[counter] and the carry register to the slice.
REQ-018 RUN: each edge SHALL write the slice sum into sum-shift bit[counter], load the slice carry into the carry register, and increment the counter.
REQ-019 RUN SHALL move to DONE on the edge that processes bit WIDTH-1; cout SHALL take that edge's slice carry.
REQ-020 Latency: with start sampled at edge 0, done SHALL be high for exactly the cycle following edge WIDTH; busy SHALL be high for the cycles following edges 0..WIDTH-1.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-022 start while busy=1 SHALL be ignored; inputs a, b and cin SHALL NOT affect an in-progress addition.
REQ-023 start during the DONE cycle SHALL be accepted (back-to-back); done SHALL still pulse for that cycle.
REQ-024 sum and cout SHALL hold the last completed result through IDLE; they SHALL change only in RUN or on reset.
REQ-025 Overflow SHALL wrap modulo 2^WIDTH in sum; the lost bit SHALL appear on cout.
REQ-026 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never exceed WIDTH-1 in RUN.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force the state to IDLE.
REQ-028 rst_n=0 SHALL immediately clear busy, done, sum, cout, the carry register, the counter and the operand registers to 0.
REQ-029 Reset asserted mid-RUN SHALL abort the addition; no done pulse SHALL follow.
REQ-030 After reset deassertion the first start SHALL be accepted normally.

Structure
REQ-031 The package student_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-032 The bit slice SHALL be one instance of the existing student_full_adder (ports a, b, c, sum, carry); no other sub-modules.

Verification (WIDTH=8)
REQ-033 a=0x03, b=0x05, cin=0, start pulse -> busy for 8 cycles, done pulse in cycle 9, sum=0x08, cout=0.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-035 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-036 Run a=0x10, b=0x20; at cycle 3 assert start with a=0xAA, b=0x55 -> second request ignored, sum=0x30, cout=0.
REQ-037 rst_n low at cycle 4 of a run -> outputs all 0 at once, no done pulse; a new start with 0x01+0x01 -> sum=0x02.
REQ-038 Run 0x0F+0x01, then start during DONE with 0x80+0x80 -> first done with sum=0x10, second done 8 cycles later with sum=0x00, cout=1.
